wb_uart_console: RTL and testbench
==================================

Name: wb_uart_console

Overview:
- Parametrised successor to the transmit-only console: a full-duplex UART behind a Wishbone B4 classic slave.
- TX FIFO and RX FIFO, each with its own parametrised depth.
- Baud divisor is programmable at run time; sticky error flags; a single level interrupt.
- Sits on the core's data bus as the console peripheral, driving the board tx pin and receiving from the rx pin.

Parameters:
- DEFAULT_DIV, 16'd434, reset value of the DIV register (clock cycles per bit).
- TX_DEPTH, 16, TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 16, RX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  write enable.
- wb_adr  in  4  byte address; only [3:2] is decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack is high.
- wb_ack  out  1  single-cycle acknowledge.
- tx  out  1  serial out; idles high.
- rx  in  1  asynchronous serial in.
- irq  out  1  level interrupt.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: tx=1, wb_ack=0, wb_dat_o=0, irq=0.
  - FIFOs empty, both FSMs in IDLE.
  - DIV=DEFAULT_DIV, CTRL=4'b0011, all sticky flags 0.
  - A reset mid-frame aborts the frame immediately.
- Bus handshake:
  - wb_ack rises the cycle after wb_cyc&wb_stb&!wb_ack and lasts exactly one cycle.
  - Register side effects happen on the cycle ack is asserted, once per ack.
  - wb_dat_o returns to 0 when ack is low.
- Register map (wb_adr[3:2]):
  - 0 DATA
    - Write: pushes wb_dat_i[7:0] into the TX FIFO. If full, the byte is dropped and TX_OVF is set.
    - Read: returns {24'b0, RX head} and pops. If the RX FIFO is empty, returns 0 and does not pop.
  - 1 STATUS (read)
    - [0] TX_EMPTY: FIFO empty and TX FSM IDLE.
    - [1] TX_FULL
    - [2] RX_VALID
    - [3] RX_FULL
    - [4] TX_OVF (sticky)
    - [5] RX_OVF (sticky)
    - [6] FRAME_ERR (sticky)
    - Writing 1 to bits [6:4] clears them; all other bits ignore writes.
  - 2 DIV
    - [15:0] read/write. A write of 0 or 1 stores 2.
  - 3 CTRL
    - [0] TX_EN, [1] RX_EN, [2] RX_IE, [3] TX_IE.
- irq = (RX_IE & RX_VALID) | (TX_IE & TX_EMPTY), registered (one cycle behind the status).
- FIFOs:
  - Circular buffers, full/empty tracked by depth-plus-one pointers.
  - A push and pop in the same cycle are both performed, including when the FIFO is full (push accepted, no overflow) or empty (push only).
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if TX_EN and FIFO not empty, pop and latch the byte and DIV; next cycle tx=0 (START).
  - Each bit lasts latched DIV cycles.
  - Data is sent LSB first, 8 bits, then STOP (tx=1) for DIV cycles.
  - A DIV change takes effect at the next frame.
  - Clearing TX_EN mid-frame finishes the current frame, then holds.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - IDLE: on a synchronised falling edge with RX_EN set, enter START and latch DIV.
  - START: wait DIV/2 cycles (truncating), then sample. If high it was a glitch: return to IDLE. Otherwise enter DATA.
  - DATA: sample 8 bits, one every DIV cycles, LSB first.
  - STOP: sample after DIV cycles.
    - Stop=0: set FRAME_ERR and discard the byte.
    - Stop=1 and FIFO full (not popped this cycle): set RX_OVF and discard.
    - Otherwise push.
  - Return to IDLE immediately after the STOP sample.
- Counters are 16 bits wide; no wrap is possible since DIV ≤ 65535.

Test Plan:
- Reset check: rst low at time 0, released after 3 clocks → tx=1, irq=0, STATUS read=0x01, DIV read=DEFAULT_DIV, CTRL read=0x3.
- TX frame: DIV=4, write DATA=0xA5 → tx waveform 0,1,0,1,0,0,1,0,1,1 with each level held 4 clocks; STATUS[0] returns to 1 after 40 clocks.
- TX overflow: DIV=100, TX_DEPTH=16, write 18 bytes back-to-back → first byte goes to the shifter, 16 are queued, the 18th is dropped; STATUS[4]=1; writing 0x10 to STATUS clears it.
- RX loopback: tie rx to tx, DIV=4, write 0x3C → STATUS[2]=1; DATA read=0x3C; second read returns 0 with STATUS[2]=0.
- RX errors:
  - Drive frame 0x55 with stop bit 0 → FRAME_ERR set, RX FIFO stays empty.
  - Send RX_DEPTH+1 valid bytes without reading → RX_FULL=1, RX_OVF=1, first 16 bytes intact in order.
  - A 1-cycle low glitch on rx → no byte, no flags.
- Interrupt and async reset: CTRL=0x7, receive 0x41 → irq=1 within 2 clocks of the push; read DATA → irq=0. Assert rst mid TX frame → tx=1 in the same cycle, FIFOs empty.

Source files
------------

// File: rtl/wb_uart_console.sv
// Console UART behind a Wishbone B4 classic slave.
// Full-duplex 8N1 UART. It has a TX FIFO and an RX FIFO, a programmable baud divisor,
// sticky error flags and one registered level interrupt.
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-low reset
//   wb_cyc, wb_stb, wb_we,
//   wb_adr, wb_dat_i              Wishbone request; register select is wb_adr[3:2]
//   wb_dat_o, wb_ack              single-cycle acknowledge; read data is zero outside ack
//   tx                            serial out, idles high
//   rx                            asynchronous serial in
//   irq                           (RX_IE & RX_VALID) | (TX_IE & TX_EMPTY), registered
module wb_uart_console #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam logic [TxAw:0] TxOne = 1;
  localparam logic [RxAw:0] RxOne = 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Bus-side state
  logic        ack_q;
  logic [31:0] dat_o_q, rdata;
  logic [15:0] div_q;
  logic [3:0]  ctrl_q;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, ferr_q, ferr_d, irq_q;
  logic        req, wr, rd, sel_data, sel_stat, sel_div, sel_ctrl;

  // FIFOs: one extra pointer bit separates full from empty
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [TxAw:0] tx_wptr_q, tx_rptr_q;
  logic [RxAw:0] rx_wptr_q, rx_rptr_q;
  logic          tx_fifo_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_empty_stat;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_ovf_set, ferr_set;

  // TX engine
  uart_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_bit_end;

  // RX engine
  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_bit_end;

  logic unused_bits;
  assign unused_bits = ^{wb_adr[1:0], wb_dat_i[31:16]};

  assign req      = wb_cyc & wb_stb & ~ack_q;
  assign wr       = req & wb_we;
  assign rd       = req & ~wb_we;
  assign sel_data = (wb_adr[3:2] == 2'd0);
  assign sel_stat = (wb_adr[3:2] == 2'd1);
  assign sel_div  = (wb_adr[3:2] == 2'd2);
  assign sel_ctrl = (wb_adr[3:2] == 2'd3);

  assign tx_fifo_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full       = (tx_wptr_q[TxAw] != tx_rptr_q[TxAw]) &&
                         (tx_wptr_q[TxAw-1:0] == tx_rptr_q[TxAw-1:0]);
  assign rx_empty      = (rx_wptr_q == rx_rptr_q);
  assign rx_full       = (rx_wptr_q[RxAw] != rx_rptr_q[RxAw]) &&
                         (rx_wptr_q[RxAw-1:0] == rx_rptr_q[RxAw-1:0]);
  assign tx_empty_stat = tx_fifo_empty & (tx_st_q == StIdle);

  assign tx_push_req = wr & sel_data;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_pop      = rd & sel_data & ~rx_empty;

  always_comb begin
    rdata = '0;
    unique case (wb_adr[3:2])
      2'd0:    rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr_q[RxAw-1:0]]};
      2'd1:    rdata = {25'd0, ferr_q, rx_ovf_q, tx_ovf_q, rx_full, ~rx_empty, tx_full,
                        tx_empty_stat};
      2'd2:    rdata = {16'd0, div_q};
      default: rdata = {28'd0, ctrl_q};
    endcase
  end

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ferr_d   = ferr_q;
    if (wr && sel_stat) begin
      if (wb_dat_i[4]) tx_ovf_d = 1'b0;
      if (wb_dat_i[5]) rx_ovf_d = 1'b0;
      if (wb_dat_i[6]) ferr_d   = 1'b0;
    end
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_ovf_set) rx_ovf_d = 1'b1;
    if (ferr_set)   ferr_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      div_q     <= DEFAULT_DIV;
      ctrl_q    <= 4'b0011;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      ack_q    <= req;
      dat_o_q  <= rd ? rdata : 32'd0;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ferr_q   <= ferr_d;
      irq_q    <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty_stat);
      if (wr && sel_div)  div_q  <= (wb_dat_i[15:1] == 15'd0) ? 16'd2 : wb_dat_i[15:0];
      if (wr && sel_ctrl) ctrl_q <= wb_dat_i[3:0];
      if (tx_push) tx_wptr_q <= tx_wptr_q + TxOne;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxOne;
      if (rx_push) rx_wptr_q <= rx_wptr_q + RxOne;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxOne;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TxAw-1:0]] <= wb_dat_i[7:0];
    if (rx_push) rx_mem[rx_wptr_q[RxAw-1:0]] <= rx_shift_q;
  end

  // TX: each level is held for the divisor latched at frame start
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_st_q)
      StIdle: begin
        tx_d = 1'b1;
        if (ctrl_q[0] && !tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rptr_q[TxAw-1:0]];
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_st_d    = StStart;
          tx_d       = 1'b0;
        end
      end
      StStart: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = StData;
          tx_d     = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      StData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: begin
        if (tx_bit_end) tx_st_d = StIdle;
        else tx_cnt_d = tx_cnt_q + 16'd1;
      end
    endcase
  end

  // RX: sample mid-bit, starting half a bit after the synchronised falling edge
  assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ovf_set = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_st_q)
      StIdle: begin
        if (ctrl_q[1] && rx_s3_q && !rx_s2_q) begin
          rx_st_d  = StStart;
          rx_div_d = div_q;
          rx_cnt_d = '0;
        end
      end
      StStart: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? StIdle : StData;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      StData: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = StStop;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      default: begin
        if (rx_bit_end) begin
          rx_st_d = StIdle;
          if (!rx_s2_q) ferr_set = 1'b1;
          else if (rx_full && !rx_pop) rx_ovf_set = 1'b1;
          else rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q    <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_st_q    <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_o_q;
  assign tx       = tx_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_wb_uart_console.sv
module tb_wb_uart_console;

  localparam logic [3:0] AData = 4'h0;
  localparam logic [3:0] AStat = 4'h4;
  localparam logic [3:0] ADiv  = 4'h8;
  localparam logic [3:0] ACtrl = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]  wb_adr;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        tx, irq, rx_drv, loopback, rx_line;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  assign rx_line = loopback ? tx : rx_drv;

  wb_uart_console dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack   (wb_ack),
    .tx       (tx),
    .rx       (rx_line),
    .irq      (irq)
  );

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                      output logic [31:0] rdat);
    int n;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wd;
    n = 0;
    do begin
      cyc1();
      n++;
    end while (!wb_ack && n < 20);
    if (!wb_ack) begin
      checks++;
      errors++;
      $display("FAIL wb_ack_timeout: got 0, expected 1");
    end
    rdat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] rdat);
    xfer(1'b0, adr, 32'd0, rdat);
  endtask

  // Drives one 8N1 frame on rx with DIV=4
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (4) cyc1();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  txf;
    int          n;

    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_i = '0;
    rx_drv = 1'b1; loopback = 1'b0;

    vecs[0]  = '{1'b0, AStat, 32'h0,         32'h01};
    vecs[1]  = '{1'b0, ADiv,  32'h0,         32'd434};
    vecs[2]  = '{1'b0, ACtrl, 32'h0,         32'h3};
    vecs[3]  = '{1'b0, AData, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, ADiv,  32'h0,         32'h0};
    vecs[5]  = '{1'b0, ADiv,  32'h0,         32'h2};
    vecs[6]  = '{1'b1, ADiv,  32'h1,         32'h0};
    vecs[7]  = '{1'b0, ADiv,  32'h0,         32'h2};
    vecs[8]  = '{1'b1, ADiv,  32'h1234_0005, 32'h0};
    vecs[9]  = '{1'b0, ADiv,  32'h0,         32'h5};
    vecs[10] = '{1'b1, ACtrl, 32'hFFFF_FFFC, 32'h0};
    vecs[11] = '{1'b0, ACtrl, 32'h0,         32'hC};
    vecs[12] = '{1'b1, ACtrl, 32'h3,         32'h0};
    vecs[13] = '{1'b0, ACtrl, 32'h0,         32'h3};
    vecs[14] = '{1'b1, AStat, 32'hFF,        32'h0};
    vecs[15] = '{1'b0, AStat, 32'h0,         32'h01};
    vecs[16] = '{1'b1, ADiv,  32'h4,         32'h0};
    vecs[17] = '{1'b0, ADiv,  32'h0,         32'h4};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    cyc1();
    rst = 1'b1;
    cyc1();

    // Register table
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].wd, d);
      if (!vecs[i].we) check($sformatf("vec%0d", i), d, vecs[i].exp);
    end
    cyc1();
    check("dat_o_idle", wb_dat_o, 32'd0);
    check("ack_single", {31'd0, wb_ack}, 32'd0);

    // TX frame 0xA5 at DIV=4
    wr(AData, 32'hA5);
    txf = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) repeat (4) exp_q.push_back(int'(txf[k]));
    n = 0;
    while (tx && n < 50) begin
      cyc1();
      n++;
    end
    check("tx_start_seen", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx_wave%0d", i), {31'd0, tx}, exp_q.pop_front());
      cyc1();
    end
    rd(AStat, d);
    check("tx_done_status", d, 32'h01);

    // Loopback 0x3C
    loopback = 1'b1;
    wr(AData, 32'h3C);
    exp_q.push_back(32'h3C);
    n = 0;
    do begin
      rd(AStat, d);
      n++;
    end while (!d[2] && n < 100);
    check("lb_rx_valid", {31'd0, d[2]}, 32'd1);
    rd(AData, d);
    check("lb_data", d, exp_q.pop_front());
    rd(AData, d);
    check("lb_empty_read", d, 32'd0);
    rd(AStat, d);
    check("lb_rx_valid_clr", {31'd0, d[2]}, 32'd0);
    repeat (10) cyc1();
    loopback = 1'b0;
    rd(AStat, d);
    check("lb_idle_status", d, 32'h01);

    // Framing error
    send_rx(8'h55, 1'b0);
    repeat (4) cyc1();
    rd(AStat, d);
    check("ferr_status", d, 32'h41);
    wr(AStat, 32'h40);
    rd(AStat, d);
    check("ferr_clear", d, 32'h01);

    // RX overflow: 17 bytes, only 16 kept
    for (int i = 0; i < 17; i++) begin
      send_rx(8'(8'h10 + i), 1'b1);
      if (i < 16) exp_q.push_back(8'h10 + i);
    end
    repeat (4) cyc1();
    rd(AStat, d);
    check("rx_ovf_status", d, 32'h2D);
    for (int i = 0; i < 16; i++) begin
      rd(AData, d);
      check($sformatf("rx_fifo%0d", i), d, exp_q.pop_front());
    end
    rd(AStat, d);
    check("rx_ovf_sticky", d, 32'h21);
    wr(AStat, 32'h20);
    rd(AStat, d);
    check("rx_ovf_clear", d, 32'h01);

    // One-cycle glitch
    rx_drv = 1'b0;
    cyc1();
    rx_drv = 1'b1;
    repeat (12) cyc1();
    rd(AStat, d);
    check("glitch_status", d, 32'h01);
    rd(AData, d);
    check("glitch_data", d, 32'd0);

    // RX interrupt
    wr(ACtrl, 32'h7);
    repeat (2) cyc1();
    check("irq_idle", {31'd0, irq}, 32'd0);
    send_rx(8'h41, 1'b1);
    exp_q.push_back(32'h41);
    repeat (3) cyc1();
    check("irq_rx", {31'd0, irq}, 32'd1);
    rd(AData, d);
    check("irq_data", d, exp_q.pop_front());
    cyc1();
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // TX interrupt on empty
    wr(ACtrl, 32'hB);
    repeat (2) cyc1();
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    wr(ACtrl, 32'h3);
    repeat (2) cyc1();
    check("irq_tx_off", {31'd0, irq}, 32'd0);

    // TX overflow at DIV=100, then reset mid-frame
    wr(ADiv, 32'd100);
    for (int i = 0; i < 18; i++) wr(AData, 32'(i));
    check("tx_mid_frame", {31'd0, tx}, 32'd0);
    rd(AStat, d);
    check("tx_ovf_status", d, 32'h12);
    wr(AStat, 32'h10);
    rd(AStat, d);
    check("tx_ovf_clear", d, 32'h02);
    rst = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    repeat (2) cyc1();
    rst = 1'b1;
    cyc1();
    rd(AStat, d);
    check("post_rst_status", d, 32'h01);
    rd(ADiv, d);
    check("post_rst_div", d, 32'd434);
    repeat (4) cyc1();
    check("post_rst_tx_idle", {31'd0, tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
